// File: rtl/dsi_cfg_pkg.sv
// dsi_cfg_pkg: shared state encoding, AXI response codes and bus-slicing helper for the DSI config arbiter
package dsi_cfg_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_t;
    localparam logic [1:0] BRESP_OKAY = 2'b00;
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction
endpackage

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: combinational round-robin pick, searching upward from the slot after ptr with wrap
import dsi_cfg_pkg::*;
module rr_arbiter_n #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    input  logic                 en_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o
);
    localparam int IW = $clog2(N);
    logic [IW-1:0] k;
    logic          found;
    // first requester at or after ptr+1 (mod N) wins; nothing is granted while disabled
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 1; i <= N; i++) begin
            k = IW'((int'(ptr_i) + i) % N);
            if (en_i && !found && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = k;
            end
        end
    end
endmodule

// File: rtl/dsi_cfg_arbiter.sv
// dsi_cfg_arbiter: shares one AXI4-Lite write port between N_REQ requesters, round-robin, with a B-response timeout
import dsi_cfg_pkg::*;
module dsi_cfg_arbiter #(
    parameter int N_REQ   = 2,
    parameter int AW      = 8,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_REQ-1:0]    req_valid_i,
    input  logic [N_REQ*AW-1:0] req_addr_i,
    input  logic [N_REQ*DW-1:0] req_data_i,
    output logic [N_REQ-1:0]    req_ready_o,
    output logic [N_REQ-1:0]    done_o,
    output logic [N_REQ-1:0]    err_o,
    output logic [AW-1:0]       awaddr_o,
    output logic                awvalid_o,
    input  logic                awready_i,
    output logic [DW-1:0]       wdata_o,
    output logic [DW/8-1:0]     wstrb_o,
    output logic                wvalid_o,
    input  logic                wready_i,
    input  logic                bvalid_i,
    input  logic [1:0]          bresp_i,
    output logic                bready_o,
    output logic                busy_o
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t           state_q;
    logic [IW-1:0]    ptr_q, gidx;
    logic [N_REQ-1:0] gnt, ptr_oh, req_ready_q, done_q, err_q;
    logic [CW-1:0]    cnt_q;
    logic [AW-1:0]    awaddr_q;
    logic [DW-1:0]    wdata_q;
    logic             awvalid_q, wvalid_q, bready_q, busy_q;
    logic             aw_hs, w_hs, addr_done_d, tmo_d;
    logic [AW-1:0]    addr_a [N_REQ];
    logic [DW-1:0]    data_a [N_REQ];

    genvar k;
    generate
        for (k = 0; k < N_REQ; k++) begin : g_unpack
            assign addr_a[k] = req_addr_i[slice_lo(k, AW) +: AW];
            assign data_a[k] = req_data_i[slice_lo(k, DW) +: DW];
        end
    endgenerate

    rr_arbiter_n #(.N(N_REQ)) u_rr (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .en_i  (state_q == IDLE),
        .gnt_o (gnt),
        .idx_o (gidx)
    );

    // AW and W complete independently; the address phase ends once neither is still outstanding
    assign aw_hs       = awvalid_q & awready_i;
    assign w_hs        = wvalid_q & wready_i;
    assign addr_done_d = (aw_hs | ~awvalid_q) & (w_hs | ~wvalid_q);
    assign tmo_d       = (TIMEOUT != 0) && (int'(cnt_q) >= TIMEOUT - 1);
    assign ptr_oh      = N_REQ'(1) << ptr_q;

    // transaction FSM: grant in IDLE, AXI handshakes in ADDR/RESP, one-cycle completion pulse from DONE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= IW'(N_REQ - 1);
            cnt_q       <= '0;
            req_ready_q <= '0;
            done_q      <= '0;
            err_q       <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            req_ready_q <= '0;
            done_q      <= '0;
            err_q       <= '0;
            if (state_q == ADDR || state_q == RESP) cnt_q <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            case (state_q)
                IDLE: if (|req_valid_i) begin
                    awaddr_q    <= addr_a[gidx];
                    wdata_q     <= data_a[gidx];
                    awvalid_q   <= 1'b1;
                    wvalid_q    <= 1'b1;
                    req_ready_q <= gnt;
                    ptr_q       <= gidx;
                    cnt_q       <= '0;
                    busy_q      <= 1'b1;
                    state_q     <= ADDR;
                end
                ADDR: if (tmo_d) begin
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b0;
                    done_q    <= ptr_oh;
                    err_q     <= ptr_oh;
                    state_q   <= DONE;
                end else begin
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs) wvalid_q <= 1'b0;
                    if (addr_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= RESP;
                    end
                end
                RESP: if (bvalid_i || tmo_d) begin
                    bready_q <= 1'b0;
                    done_q   <= ptr_oh;
                    err_q    <= (!bvalid_i || bresp_i != BRESP_OKAY) ? ptr_oh : '0;
                    state_q  <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign awaddr_o    = awaddr_q;
    assign awvalid_o   = awvalid_q;
    assign wdata_o     = wdata_q;
    assign wstrb_o     = {(DW/8){wvalid_q}};
    assign wvalid_o    = wvalid_q;
    assign bready_o    = bready_q;
    assign busy_o      = busy_q;
endmodule

// File: tb/tb_dsi_cfg_arbiter.sv
// tb_dsi_cfg_arbiter: directed vectors and hand-written sequences for the DSI config-write arbiter
module tb_dsi_cfg_arbiter;
    localparam int N  = 2;
    localparam int AW = 8;
    localparam int DW = 32;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [N-1:0]    req_valid_i;
    logic [N*AW-1:0] req_addr_i;
    logic [N*DW-1:0] req_data_i;
    logic [N-1:0]    req_ready_o, done_o, err_o;
    logic [AW-1:0]   awaddr_o;
    logic            awvalid_o, awready_i;
    logic [DW-1:0]   wdata_o;
    logic [DW/8-1:0] wstrb_o;
    logic            wvalid_o, wready_i, bvalid_i, bready_o, busy_o;
    logic [1:0]      bresp_i;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic [1:0]  req;
        logic [7:0]  a0;
        logic [31:0] d0;
        logic [7:0]  a1;
        logic [31:0] d1;
        logic [1:0]  bresp;
        logic [7:0]  ea;
        logic [31:0] ed;
        logic        eerr;
    } vec_t;
    vec_t tbl [6];

    dsi_cfg_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .awaddr_o    (awaddr_o),
        .awvalid_o   (awvalid_o),
        .awready_i   (awready_i),
        .wdata_o     (wdata_o),
        .wstrb_o     (wstrb_o),
        .wvalid_o    (wvalid_o),
        .wready_i    (wready_i),
        .bvalid_i    (bvalid_i),
        .bresp_i     (bresp_i),
        .bready_o    (bready_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc;
        @(negedge clk_i);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input int i);
        req_valid_i = v.req;
        req_addr_i  = {v.a1, v.a0};
        req_data_i  = {v.d1, v.d0};
        bresp_i     = v.bresp;
        awready_i   = 1'b1;
        wready_i    = 1'b1;
        bvalid_i    = 1'b1;
        cyc;
        chk($sformatf("v%0d_ready", i), 64'(req_ready_o), 64'(v.req));
        chk($sformatf("v%0d_awvalid", i), 64'(awvalid_o), 64'(1));
        chk($sformatf("v%0d_wvalid", i), 64'(wvalid_o), 64'(1));
        chk($sformatf("v%0d_awaddr", i), 64'(awaddr_o), 64'(v.ea));
        chk($sformatf("v%0d_wdata", i), 64'(wdata_o), 64'(v.ed));
        chk($sformatf("v%0d_wstrb", i), 64'(wstrb_o), 64'(4'hF));
        chk($sformatf("v%0d_bready0", i), 64'(bready_o), 64'(0));
        chk($sformatf("v%0d_busy", i), 64'(busy_o), 64'(1));
        req_valid_i = '0;
        cyc;
        chk($sformatf("v%0d_awvalid_clr", i), 64'({awvalid_o, wvalid_o, wstrb_o}), 64'(0));
        chk($sformatf("v%0d_bready1", i), 64'(bready_o), 64'(1));
        chk($sformatf("v%0d_ready_clr", i), 64'(req_ready_o), 64'(0));
        cyc;
        chk($sformatf("v%0d_bready_clr", i), 64'(bready_o), 64'(0));
        chk($sformatf("v%0d_done", i), 64'(done_o), 64'(v.req));
        chk($sformatf("v%0d_err", i), 64'(err_o), 64'(v.eerr ? v.req : 2'b00));
        cyc;
        chk($sformatf("v%0d_done_clr", i), 64'({done_o, err_o}), 64'(0));
        chk($sformatf("v%0d_idle", i), 64'(busy_o), 64'(0));
    endtask

    task automatic split(input logic [1:0] r, input logic [7:0] a, input logic [31:0] d,
                         input int aw_at, input int w_at);
        int lst = (aw_at > w_at) ? aw_at : w_at;
        req_valid_i = r;
        req_addr_i  = {a, a};
        req_data_i  = {d, d};
        awready_i   = 1'b0;
        wready_i    = 1'b0;
        bvalid_i    = 1'b1;
        bresp_i     = 2'b00;
        for (int k = 1; k <= lst; k++) begin
            cyc;
            if (k == 1) begin
                chk("split_ready", 64'(req_ready_o), 64'(r));
                req_valid_i = '0;
            end
            chk("split_awvalid", 64'(awvalid_o), 64'(k <= aw_at));
            chk("split_wvalid", 64'(wvalid_o), 64'(k <= w_at));
            chk("split_bready", 64'(bready_o), 64'(0));
            if (k <= aw_at) chk("split_awaddr", 64'(awaddr_o), 64'(a));
            if (k <= w_at) chk("split_wdata", 64'(wdata_o), 64'(d));
            awready_i = (k == aw_at);
            wready_i  = (k == w_at);
        end
        cyc;
        chk("split_valids_clr", 64'({awvalid_o, wvalid_o}), 64'(0));
        chk("split_bready_rise", 64'(bready_o), 64'(1));
        awready_i = 1'b0;
        wready_i  = 1'b0;
        cyc;
        chk("split_done", 64'(done_o), 64'(r));
        chk("split_err", 64'(err_o), 64'(0));
        cyc;
    endtask

    initial begin
        logic [1:0] last_g;
        int g, d, lastc;
        tbl[0] = '{2'b01, 8'h40, 32'h000014C8, 8'hEE, 32'hDEAD0000, 2'b00, 8'h40, 32'h000014C8, 1'b0};
        tbl[1] = '{2'b10, 8'hEE, 32'hDEAD0001, 8'h18, 32'h0000000A, 2'b10, 8'h18, 32'h0000000A, 1'b1};
        tbl[2] = '{2'b01, 8'h7C, 32'hA5A50F0F, 8'hEE, 32'hDEAD0002, 2'b01, 8'h7C, 32'hA5A50F0F, 1'b1};
        tbl[3] = '{2'b10, 8'hEE, 32'hDEAD0003, 8'hFF, 32'hFFFFFFFF, 2'b00, 8'hFF, 32'hFFFFFFFF, 1'b0};
        tbl[4] = '{2'b10, 8'hEE, 32'hDEAD0004, 8'h00, 32'h00000001, 2'b11, 8'h00, 32'h00000001, 1'b1};
        tbl[5] = '{2'b01, 8'h01, 32'h80000000, 8'hEE, 32'hDEAD0005, 2'b00, 8'h01, 32'h80000000, 1'b0};
        req_valid_i = '0;
        req_addr_i  = '0;
        req_data_i  = '0;
        awready_i   = 1'b0;
        wready_i    = 1'b0;
        bvalid_i    = 1'b0;
        bresp_i     = 2'b00;
        repeat (3) cyc;
        chk("rst_valids", 64'({awvalid_o, wvalid_o, bready_o, busy_o}), 64'(0));
        chk("rst_pulses", 64'({req_ready_o, done_o, err_o}), 64'(0));
        chk("rst_bus", 64'({awaddr_o, wdata_o, wstrb_o}), 64'(0));
        rst_i = 1'b0;
        cyc;
        // both requesters held: grants alternate 0,1,0,1 four edges apart
        awready_i   = 1'b1;
        wready_i    = 1'b1;
        bvalid_i    = 1'b1;
        req_addr_i  = {8'h22, 8'h11};
        req_data_i  = {32'h22222222, 32'h11111111};
        req_valid_i = 2'b11;
        g = 0;
        d = 0;
        lastc = 0;
        last_g = '0;
        for (int c = 0; c < 40 && d < 4; c++) begin
            cyc;
            if (req_ready_o != '0) begin
                chk("cont_grant", 64'(req_ready_o), 64'((g % 2 == 0) ? 2'b01 : 2'b10));
                chk("cont_addr", 64'(awaddr_o), 64'((g % 2 == 0) ? 8'h11 : 8'h22));
                if (g > 0) chk("cont_spacing", 64'(c - lastc), 64'(4));
                lastc = c;
                last_g = req_ready_o;
                g++;
            end
            if (done_o != '0) begin
                chk("cont_done", 64'(done_o), 64'(last_g));
                chk("cont_err", 64'(err_o), 64'(0));
                d++;
                if (d == 4) req_valid_i = '0;
            end
        end
        chk("cont_count", 64'(d), 64'(4));
        cyc;
        for (int i = 0; i < 6; i++) run_vec(tbl[i], i);
        split(2'b01, 8'h33, 32'hDEADBEEF, 2, 5);
        split(2'b10, 8'h44, 32'h00000005, 3, 3);
        split(2'b01, 8'h55, 32'hCAFEF00D, 3, 1);
        // slave never answers: timeout completes req1 with error, then pending req0 proceeds normally
        req_valid_i = 2'b11;
        req_addr_i  = {8'h5A, 8'hA5};
        req_data_i  = {32'h5A5A5A5A, 32'hA5A5A5A5};
        awready_i   = 1'b1;
        wready_i    = 1'b1;
        bvalid_i    = 1'b0;
        bresp_i     = 2'b00;
        for (int k = 1; k <= 21; k++) begin
            cyc;
            chk("to_bready", 64'(bready_o), 64'((k >= 2 && k <= 16) || k == 20));
            chk("to_done", 64'(done_o), 64'(k == 17 ? 2'b10 : k == 21 ? 2'b01 : 2'b00));
            chk("to_err", 64'(err_o), 64'(k == 17 ? 2'b10 : 2'b00));
            chk("to_ready", 64'(req_ready_o), 64'(k == 1 ? 2'b10 : k == 19 ? 2'b01 : 2'b00));
            if (k == 19) chk("to_addr", 64'(awaddr_o), 64'(8'hA5));
            if (k == 1) req_valid_i = 2'b01;
            if (k == 17) bvalid_i = 1'b1;
            if (k == 19) req_valid_i = '0;
        end
        cyc;
        // reset while waiting in RESP: everything drops at once, no completion, req0 wins afterwards
        req_valid_i = 2'b01;
        req_addr_i  = {8'h77, 8'h66};
        req_data_i  = {32'h77777777, 32'h66666666};
        bvalid_i    = 1'b0;
        cyc;
        chk("rr_ready", 64'(req_ready_o), 64'(2'b01));
        req_valid_i = '0;
        cyc;
        chk("rr_in_resp", 64'({bready_o, busy_o}), 64'(2'b11));
        req_valid_i = 2'b11;
        rst_i = 1'b1;
        #1;
        chk("rr_async_valids", 64'({awvalid_o, wvalid_o, bready_o, busy_o, wstrb_o}), 64'(0));
        chk("rr_async_pulses", 64'({req_ready_o, done_o, err_o}), 64'(0));
        bvalid_i = 1'b1;
        cyc;
        chk("rr_no_done", 64'({done_o, err_o}), 64'(0));
        rst_i = 1'b0;
        cyc;
        chk("rr_post_grant", 64'(req_ready_o), 64'(2'b01));
        chk("rr_post_addr", 64'(awaddr_o), 64'(8'h66));
        req_valid_i = 2'b10;
        cyc;
        chk("rr_post_bready", 64'(bready_o), 64'(1));
        cyc;
        chk("rr_post_done", 64'(done_o), 64'(2'b01));
        chk("rr_post_err", 64'(err_o), 64'(0));
        req_valid_i = '0;
        repeat (2) cyc;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dsi_cfg_arbiter.md
Name: dsi_cfg_arbiter

Overview:
- Shares the single AXI4-Lite register-write port of the DSI host controller between N_REQ independent requesters, e.g. the power-up init sequencer and a runtime timing/brightness controller.
- Each requester presents a simple valid/ready single-write request.
- The block arbitrates round-robin and runs the AXI-Lite AW/W/B handshakes.
- It returns a per-requester completion pulse with an error flag, and a timeout prevents a hung slave from locking the bus.

Parameters:
N_REQ, 2, number of requesters (2..8)
AW, 8, register address width
DW, 32, register data width
TIMEOUT, 1023, max cycles from AXI issue to B handshake; 0 disables timeout

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
req_valid_i  in  N_REQ  per-requester write request; held until req_ready_o
req_addr_i  in  N_REQ*AW  packed addresses, requester k at [k*AW +: AW]
req_data_i  in  N_REQ*DW  packed data, requester k at [k*DW +: DW]
req_ready_o  out  N_REQ  one-cycle accept pulse, one-hot
done_o  out  N_REQ  one-cycle completion pulse, one-hot
err_o  out  N_REQ  valid with done_o; 1 = non-OKAY bresp or timeout
awaddr_o  out  AW  AXI write address
awvalid_o  out  1  AXI AW valid
awready_i  in  1  AXI AW ready
wdata_o  out  DW  AXI write data
wstrb_o  out  DW/8  all ones whenever wvalid_o=1, else 0
wvalid_o  out  1  AXI W valid
wready_i  in  1  AXI W ready
bvalid_i  in  1  AXI B valid
bresp_i  in  2  AXI B response
bready_o  out  1  AXI B ready
busy_o  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered. Reset values: every output 0, state IDLE, rr pointer = N_REQ-1 (so requester 0 wins first), timeout counter 0.
- FSM states: IDLE, ADDR, RESP, DONE.
- IDLE: on any clock edge with req_valid_i != 0, pick the winner: the first set bit searching from (ptr+1) mod N_REQ upward with wrap.
  - Latch the winner's addr/data into awaddr_o/wdata_o.
  - Set awvalid_o=wvalid_o=1 and pulse req_ready_o[winner].
  - Set ptr=winner; go to ADDR.
  - Requests are sampled only in IDLE. A requester deasserting valid before ready is a protocol violation; behaviour is undefined.
- ADDR:
  - awvalid_o clears on the edge where awready_i=1; wvalid_o clears on the edge where wready_i=1, independently and in either order or the same cycle.
  - Each valid is held stable with address/data until its own handshake.
  - When both handshakes have completed (including same-edge), go to RESP with bready_o=1.
- RESP: on the edge with bvalid_i & bready_o, clear bready_o, record err = (bresp_i != 2'b00), go to DONE.
- DONE: pulse done_o[ptr] and err_o[ptr] for exactly one cycle; next state IDLE.
- Back-to-back: a still-pending request can be granted on the edge leaving DONE→IDLE+1, so minimum spacing between grants is 4 cycles with zero-wait slave (grant, ADDR, RESP, DONE).
- Latency: req_valid seen in IDLE at edge T → awvalid_o high from T+1. Zero-wait slave → bready_o high T+2, done_o at T+3.
- Timeout:
  - The counter clears at grant and increments each cycle in ADDR/RESP.
  - When TIMEOUT != 0 and the counter reaches TIMEOUT, drop awvalid_o/wvalid_o/bready_o, go to DONE with err=1.
  - A B handshake on the same edge as the timeout wins (normal completion).
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,N_REQ-1,0. No requester waits more than N_REQ-1 transactions.
- Reset mid-transaction: all valids/readies drop asynchronously, and no done_o is issued for the aborted write.
- The counter width is $clog2(TIMEOUT+1) and it saturates and never wraps.

Decomposition:
- Package dsi_cfg_pkg holds:
  - state enum (IDLE, ADDR, RESP, DONE)
  - BRESP_OKAY = 2'b00
  - a function for packed-bus slicing
- Sub-module rr_arbiter_n (parameter N): inputs req, ptr, enable; outputs a one-hot grant and its index. It is purely combinational and used only in IDLE.

Test Plan:
- Single write: req0 addr 0x40 data 0x000014C8, slave always ready, bresp=00 → awvalid/wvalid 1 cycle at T+1, bready T+2, done_o=01 err_o=00 at T+3.
- Contention: req0 and req1 held valid together for 4 transactions → grant order 0,1,0,1. Each done_o is one-hot matching its grant, with ≥4 cycles between grants.
- Split handshakes: awready at cycle 2 and wready at cycle 5 after grant → awaddr/wdata stable while valid; bready rises only after cycle 5; also cover the same-edge aw/w case.
- Error: bresp=2'b10 for req1 addr 0x18 data 0x0A → done_o=10, err_o=10.
- Timeout: TIMEOUT=16, slave never asserts bvalid → bready drops 16 cycles after grant, done+err pulse follows, and the next pending request is then granted normally.
- Reset: assert rst_i while in RESP → all outputs 0 immediately, no done_o. After release, a pending req0 is granted first.
